// File: rtl/serial_clock_gen.sv
// Serial clock generator: produces a programmable-rate sclk in frames of
// frame_len+1 periods, with lead/trail/sample/shift strobes aligned to the
// sclk edges, optional back-to-back frame chaining, and synchronous abort.
module serial_clock_gen #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             cont,
  input  logic             start,
  input  logic             stop,
  output logic             sclk,
  output logic             lead,
  output logic             trail,
  output logic             sample,
  output logic             shift,
  output logic             frame_start,
  output logic             done,
  output logic             busy,
  output logic [LEN_W-1:0] bit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_q, hc;
  logic [LEN_W-1:0] len_q;
  logic             cpol_q, cpha_q;
  // One extra bit so 2*(len_q+1) toggles fit even at the maximum frame_len.
  logic [LEN_W:0]   edge_cnt;

  logic accept, tick, lead_edge, trail_edge, last_edge, relatch;

  // Next-state decode and edge classification for the current cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    tick       = 1'b0;
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    last_edge  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (hc == div_q) begin
          tick       = 1'b1;
          // Even toggle count: sclk is at idle level, so this toggle leaves it.
          lead_edge  = ~edge_cnt[0];
          trail_edge = edge_cnt[0];
          last_edge  = (edge_cnt == {len_q, 1'b1});
          if (last_edge && !cont) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A new frame's configuration is captured on accept and on a chained done.
  assign relatch = accept | (last_edge & cont);

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the latched configuration is a handful of flops, not a memory, so it is reset along with everything else.
    if (!rst_n) begin
      state       <= IDLE;
      div_q       <= '0;
      len_q       <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      hc          <= '0;
      edge_cnt    <= '0;
      sclk        <= 1'b0;
      lead        <= 1'b0;
      trail       <= 1'b0;
      sample      <= 1'b0;
      shift       <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      bit_idx     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_next;
      busy        <= (state_next == RUN);
      lead        <= lead_edge;
      trail       <= trail_edge;
      sample      <= cpha_q ? trail_edge : lead_edge;
      shift       <= cpha_q ? lead_edge : trail_edge;
      frame_start <= lead_edge && (edge_cnt == '0);
      done        <= last_edge;

      if (relatch) begin
        div_q    <= div;
        len_q    <= frame_len;
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        hc       <= '0;
        edge_cnt <= '0;
      end else if (tick) begin
        hc       <= '0;
        edge_cnt <= edge_cnt + 1'b1;
      end else if (state == RUN) begin
        hc <= hc + 1'b1;
      end else begin
        hc       <= '0;
        edge_cnt <= '0;
      end

      if (state == IDLE) begin
        sclk <= cpol;
      end else if (stop) begin
        sclk <= cpol_q;
      end else if (tick) begin
        sclk <= lead_edge ? ~cpol_q : cpol_q;
      end

      if (state_next != RUN || relatch) begin
        bit_idx <= '0;
      end else if (trail_edge) begin
        bit_idx <= (bit_idx == len_q) ? len_q : bit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_clock_gen.sv
// Directed bench for serial_clock_gen: single frames in both clock modes,
// chained frames, abort with stop, and asynchronous reset mid-frame.
module tb_serial_clock_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div;
  logic [3:0] frame_len;
  logic       cpol, cpha, cont, start, stop;
  logic       sclk, lead, trail, sample, shift, frame_start, done, busy;
  logic [3:0] bit_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  serial_clock_gen #(.DIV_W(8), .LEN_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div         (div),
    .frame_len   (frame_len),
    .cpol        (cpol),
    .cpha        (cpha),
    .cont        (cont),
    .start       (start),
    .stop        (stop),
    .sclk        (sclk),
    .lead        (lead),
    .trail       (trail),
    .sample      (sample),
    .shift       (shift),
    .frame_start (frame_start),
    .done        (done),
    .busy        (busy),
    .bit_idx     (bit_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else pass_cnt++;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one non-chained frame against a closed-form model of the waveform:
  // after c cycles, k = c/(d+1) toggles have happened.
  task automatic run_frame(input string tag, input int d, input int l,
                           input logic cp, input logic ch,
                           output int n_smp, output int n_fs, output int n_done,
                           output int done_cyc, output int first_tog);
    int n, k, errs, bexp;
    logic tk, ld, tr;
    div = 8'(d); frame_len = 4'(l); cpol = cp; cpha = ch; cont = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after accept"}, busy, 1);
    n = 2 * (l + 1) * (d + 1);
    errs = 0; n_smp = 0; n_fs = 0; n_done = 0; done_cyc = -1; first_tog = -1;
    for (int c = 1; c <= n; c++) begin
      step();
      k  = c / (d + 1);
      tk = (c % (d + 1)) == 0;
      ld = tk && (k % 2 == 1);
      tr = tk && (k % 2 == 0);
      bexp = (c < n) ? k / 2 : 0;
      if (sclk   !== (cp ^ (k % 2 == 1))) errs++;
      if (lead   !== ld) errs++;
      if (trail  !== tr) errs++;
      if (sample !== (ch ? tr : ld)) errs++;
      if (shift  !== (ch ? ld : tr)) errs++;
      if (busy   !== (c < n)) errs++;
      if (bit_idx != 4'(bexp)) errs++;
      if (sample) n_smp++;
      if (frame_start) n_fs++;
      if (done) begin n_done++; done_cyc = c; end
      if (first_tog < 0 && sclk !== cp) first_tog = c;
    end
    check({tag, " waveform errors"}, errs, 0);
    step();
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle bit_idx"}, bit_idx, 0);
    check({tag, " idle sclk"}, sclk, cp);
  endtask

  int n_smp, n_fs, n_done, done_cyc, first_tog, errs, k, cc, busy_low;

  initial begin
    div = 8'd0; frame_len = 4'd0; cpol = 1'b0; cpha = 1'b0;
    cont = 1'b0; start = 1'b0; stop = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset sclk", sclk, 0);
    check("reset busy", busy, 0);
    check("reset bit_idx", bit_idx, 0);
    check("reset done", done, 0);
    #20;
    rst_n = 1'b1;
    step();
    step();
    check("idle sclk cpol0", sclk, 0);

    // div=3, frame_len=7, mode 0: 8 periods of 8 cycles.
    run_frame("A", 3, 7, 1'b0, 1'b0, n_smp, n_fs, n_done, done_cyc, first_tog);
    check("A first rise", first_tog, 4);
    check("A samples", n_smp, 8);
    check("A frame_start", n_fs, 1);
    check("A done count", n_done, 1);
    check("A done cycle", done_cyc, 64);

    // cpol=1, cpha=1, div=0, frame_len=2: toggles every cycle.
    cpol = 1'b1;
    step();
    step();
    check("B idle high", sclk, 1);
    run_frame("B", 0, 2, 1'b1, 1'b1, n_smp, n_fs, n_done, done_cyc, first_tog);
    check("B first fall", first_tog, 1);
    check("B samples", n_smp, 3);
    check("B done cycle", done_cyc, 6);

    // Chained frames: div=1, frame_len=1, 8 cycles per frame, 3 frames.
    div = 8'd1; frame_len = 4'd1; cpol = 1'b0; cpha = 1'b0; cont = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    errs = 0; n_fs = 0; n_done = 0; done_cyc = -1; busy_low = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      cc = ((c - 1) % 8) + 1;
      k  = cc / 2;
      if (sclk !== (k % 2 == 1)) errs++;
      if (bit_idx != 4'((cc == 8) ? 0 : k / 2)) errs++;
      if (c < 24 && !busy) busy_low++;
      if (frame_start) n_fs++;
      if (done) begin n_done++; done_cyc = c; end
      if (c == 16) cont = 1'b0;
    end
    check("C waveform errors", errs, 0);
    check("C busy gaps", busy_low, 0);
    check("C frame_start", n_fs, 3);
    check("C done count", n_done, 3);
    check("C last done cycle", done_cyc, 24);
    check("C idle after 3rd", busy, 0);
    step();
    check("C stays idle", busy, 0);

    // Abort with stop at cycle 10; start alongside stop is ignored.
    div = 8'd3; frame_len = 4'd7; cpol = 1'b1; cpha = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (done) n_done++;
    end
    check("D sclk before stop", sclk, 1);
    check("D bit_idx before stop", bit_idx, 1);
    stop = 1'b1; start = 1'b1;
    step();
    check("D busy after stop", busy, 0);
    check("D sclk after stop", sclk, 1);
    check("D no done on stop", done, 0);
    check("D no sample on stop", sample, 0);
    step();
    check("D stop beats start", busy, 0);
    stop = 1'b0; start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || busy) n_done++;
    end
    check("D no done or restart", n_done, 0);

    // Async reset mid-frame with sclk high.
    cpol = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) step();
    check("E sclk high mid-frame", sclk, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("E async sclk", sclk, 0);
    check("E async busy", busy, 0);
    cpol = 1'b1;
    #3;
    rst_n = 1'b1;
    step();
    check("E sclk follows cpol", sclk, 1);
    check("E busy after release", busy, 0);
    run_frame("E", 1, 3, 1'b1, 1'b0, n_smp, n_fs, n_done, done_cyc, first_tog);
    check("E samples", n_smp, 4);
    check("E done cycle", done_cyc, 16);
    check("E frame_start", n_fs, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_clock_gen.md
SERIAL_CLOCK_GEN -- requirements
Module: serial_clock_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of the half-period divider input.
REQ-002 Parameter LEN_W, default 4, width of the frame-length input and bit index.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 div  input  DIV_W  sclk half-period minus one, in clk cycles; latched at frame start.
REQ-006 frame_len  input  LEN_W  sclk periods per frame minus one; latched at frame start.
REQ-007 cpol  input  1  sclk idle level; latched at frame start.
REQ-008 cpha  input  1  0: sample on leading edge; 1: sample on trailing edge; latched at frame start.
REQ-009 cont  input  1  1: chain the next frame with no gap.
REQ-010 start  input  1  frame request, sampled only in IDLE.
REQ-011 stop  input  1  synchronous abort.
REQ-012 sclk  output  1  generated serial clock.
REQ-013 lead / trail  output  1 each  one-cycle strobes on the sclk edge leaving / returning to idle level.
REQ-014 sample / shift  output  1 each  one-cycle strobes: sample = cpha ? trail : lead; shift = cpha ? lead : trail.
REQ-015 frame_start  output  1  one-cycle strobe on the first lead edge of each frame.
REQ-016 done  output  1  one-cycle strobe on the final trail edge of a completed frame.
REQ-017 busy  output  1  high while in RUN.
REQ-018 bit_idx  output  LEN_W  number of completed sclk periods in the current frame.

Function
REQ-019 FSM states: IDLE and RUN only.
REQ-020 IDLE to RUN on the edge where start=1 and stop=0.
  - On that edge: latch div_q, len_q, cpol_q, cpha_q.
  - Clear hc (half-period counter) and edge_cnt.
  - busy goes to 1 on the same edge.
REQ-021 In IDLE, sclk is registered from the live cpol every cycle. All strobes are 0 and bit_idx is 0.
REQ-022 In RUN, on each edge:
  - if hc == div_q: hc goes to 0, sclk toggles, edge_cnt increments;
  - otherwise hc increments.
REQ-023 Each strobe is registered and asserts on the same edge as the sclk toggle it marks.
REQ-024 The first toggle occurs div_q+1 cycles after the start-accept edge.
  - Every sclk high and low phase lasts exactly div_q+1 cycles.
REQ-025 A frame has 2*(len_q+1) toggles. bit_idx increments on each trail edge and saturates at len_q.
REQ-026 Final trail edge (edge_cnt == 2*len_q+1 at toggle): done=1, and sclk returns to cpol_q.
  - If cont=1 on that cycle: relatch all config inputs, clear counters, stay in RUN with busy held high. The next frame's first lead edge follows after div+1 cycles.
  - If cont=0: go to IDLE and drop busy on that edge.
REQ-027 stop=1 in RUN: go to IDLE on the next edge.
  - sclk goes to cpol_q and busy to 0.
  - No done and no strobes on that edge.
REQ-028 stop and start asserted together in IDLE: stop wins and the frame is not started.
REQ-029 start asserted while busy is ignored; config input changes in RUN have no effect until the next latch.
REQ-030 div=0 gives sclk = clk/2 with strobes on every cycle. frame_len=0 gives a one-period frame.
REQ-031 Maximum values (div = 2^DIV_W-1, frame_len = 2^LEN_W-1) operate without counter overflow.
  - edge_cnt is LEN_W+1 bits wide.

Reset
REQ-032 rst_n=0 asynchronously forces: state IDLE, sclk 0, busy 0, all strobes 0, bit_idx 0, counters 0, latched config 0.
REQ-033 Reset mid-frame aborts the frame with no done pulse.
  - From the first edge after rst_n rises, sclk follows cpol per REQ-021.

Verification
REQ-034 div=3, frame_len=7, cpol=0, cpha=0, cont=0, single start pulse:
  - first rise 4 cycles after accept;
  - 8 periods of 8 cycles each;
  - 8 sample strobes on rises, frame_start once, done once at cycle 64;
  - busy high for 64 cycles.
REQ-035 cpol=1, cpha=1, div=0, frame_len=2:
  - sclk idles high and toggles every cycle;
  - sample asserts on rising (trail) edges, 3 times;
  - done at cycle 6.
REQ-036 cont=1, div=1, frame_len=1, held for 3 frames:
  - no gap between frames and busy never drops;
  - done and frame_start pulse 3 times each.
  - Then clear cont: IDLE after the 3rd done.
REQ-037 stop asserted at cycle 10 of a div=3, frame_len=7 frame:
  - next edge: busy=0 and sclk=cpol;
  - no done;
  - start asserted with stop in the same cycle is ignored.
REQ-038 rst_n pulled low mid-frame between clock edges:
  - outputs reset immediately;
  - after release with cpol=1, sclk=1 one cycle later;
  - a new start runs a correct frame.
